// File: rtl/ddr3_line_pkg.sv
// Shared definitions for the DDR3 line responder and the controller side:
// default line/address widths, counter width and the responder FSM states.
package ddr3_line_pkg;

    localparam int LINE_DATA_W = 256;
    localparam int LINE_ADDR_W = 32;
    localparam int LINE_CNT_W  = 8;   // wide enough for LATENCY up to 255

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } line_state_e;

endpackage

// File: rtl/ddr3_line_ram.sv
// Single-port line store: synchronous write, registered read with an
// optional force-to-zero on the read path. Only the read register is reset.
module ddr3_line_ram
    import ddr3_line_pkg::*;
#(
    parameter int DATA_W     = LINE_DATA_W,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic                  rd_clr,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // NOTE: the array has no reset branch so it maps onto RAM macros; only
    // control and output registers need a defined value after reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // rdata is the responder's data_o: it moves only on a read commit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_clr ? '0 : mem[addr];
        end
    end

endmodule

// File: rtl/ddr3_line_resp.sv
// Level-request / pulse-ack line responder with a fixed LATENCY from capture
// to ack. Define LINE_RESP_ERR_EN to flag (and suppress) out-of-range lines.
module ddr3_line_resp
    import ddr3_line_pkg::*;
#(
    parameter int DATA_W     = LINE_DATA_W,
    parameter int ADDR_W     = LINE_ADDR_W,
    parameter int DEPTH_LOG2 = 4,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              we_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ack_o,
    output logic              err_o
);

    line_state_e           state;
    logic [LINE_CNT_W-1:0] cnt;
    logic [ADDR_W-1:0]     cap_addr;
    logic [DATA_W-1:0]     cap_data;
    logic                  cap_we;

    logic                  req;
    logic                  commit;
    logic [ADDR_W-1:0]     cmt_addr;
    logic [DATA_W-1:0]     cmt_data;
    logic                  cmt_we;
    logic                  addr_bad;
    logic                  ram_we;
    logic                  ram_re;

    assign req = we_i | rd_i;

    // The commit edge is the edge entering ACK. With LATENCY==1 that is the
    // capture edge itself, so the live inputs feed the store directly.
    assign commit = rst && (((state == BUSY) && (cnt <= LINE_CNT_W'(1))) ||
                            ((state == IDLE) && req && (LATENCY == 1)));

    assign cmt_addr = (state == IDLE) ? addr_i : cap_addr;
    assign cmt_data = (state == IDLE) ? data_i : cap_data;
    assign cmt_we   = (state == IDLE) ? we_i   : cap_we;

`ifdef LINE_RESP_ERR_EN
    assign addr_bad = |cmt_addr[ADDR_W-1:DEPTH_LOG2];
`else
    // Upper address bits alias onto the stored lines.
    logic unused_addr_hi;
    assign unused_addr_hi = ^cmt_addr[ADDR_W-1:DEPTH_LOG2];
    assign addr_bad       = 1'b0;
`endif

    assign ram_we = commit && cmt_we && !addr_bad;
    assign ram_re = commit && !cmt_we;

    ddr3_line_ram #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (ram_we),
        .re     (ram_re),
        .rd_clr (addr_bad),
        .addr   (cmt_addr[DEPTH_LOG2-1:0]),
        .wdata  (cmt_data),
        .rdata  (data_o)
    );

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            ack_o    <= 1'b0;
            err_o    <= 1'b0;
            cap_addr <= '0;
            cap_data <= '0;
            cap_we   <= 1'b0;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        cap_addr <= addr_i;
                        cap_data <= data_i;
                        cap_we   <= we_i;   // write wins when both are high
                        if (LATENCY == 1) begin
                            state <= ACK;
                            cnt   <= '0;
                            ack_o <= 1'b1;
                            err_o <= addr_bad;
                        end else begin
                            state <= BUSY;
                            cnt   <= LINE_CNT_W'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (cnt <= LINE_CNT_W'(1)) begin
                        state <= ACK;
                        cnt   <= '0;
                        ack_o <= 1'b1;
                        err_o <= addr_bad;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    // Requests still held here are not re-captured.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_line_resp.sv
// Scoreboard bench for ddr3_line_resp at LATENCY 4, 1 and 8: requests push
// the expected ack cycle, err and data_o; a negedge monitor pops and compares.
module tb_ddr3_line_resp;
    import ddr3_line_pkg::*;

    localparam int DW = 256;
    localparam int AW = 32;
`ifdef LINE_RESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic        err;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lat [3] = '{4, 1, 8};

    logic [AW-1:0] addr_v [3];
    logic [DW-1:0] data_v [3];
    logic          we_v   [3];
    logic          rd_v   [3];
    logic [DW-1:0] dout0, dout1, dout2;
    logic          ack0, ack1, ack2;
    logic          err0, err1, err2;

    exp_t exp_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ddr3_line_resp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(4), .LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .addr_i(addr_v[0]), .data_i(data_v[0]),
        .we_i(we_v[0]), .rd_i(rd_v[0]), .data_o(dout0), .ack_o(ack0), .err_o(err0));
    ddr3_line_resp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(4), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .addr_i(addr_v[1]), .data_i(data_v[1]),
        .we_i(we_v[1]), .rd_i(rd_v[1]), .data_o(dout1), .ack_o(ack1), .err_o(err1));
    ddr3_line_resp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH_LOG2(4), .LATENCY(8)) dut2 (
        .clk(clk), .rst(rst), .addr_i(addr_v[2]), .data_i(data_v[2]),
        .we_i(we_v[2]), .rd_i(rd_v[2]), .data_o(dout2), .ack_o(ack2), .err_o(err2));

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic get_ack(input int idx);
        case (idx)
            0:       return ack0;
            1:       return ack1;
            default: return ack2;
        endcase
    endfunction

    task automatic mon_step(input int idx, input logic a, input logic e, input logic [DW-1:0] d);
        exp_t x;
        if (a === 1'b1) begin
            if (exp_q[idx].size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL dut%0d_unexpected_ack: ack_o got 1 expected 0 (cycle %0d)", idx, cyc);
            end else begin
                x = exp_q[idx].pop_front();
                check($sformatf("dut%0d_ack_cycle", idx), DW'(cyc), DW'(x.cyc));
                check($sformatf("dut%0d_err", idx), DW'(e), DW'(x.err));
                check($sformatf("dut%0d_data", idx), d, x.data);
            end
        end
    endtask

    // Ack is visible in the cycle after edge T+LATENCY-1 (sampled at edge T+LATENCY).
    always @(negedge clk) begin
        mon_step(0, ack0, err0, dout0);
        mon_step(1, ack1, err1, dout1);
        mon_step(2, ack2, err2, dout2);
    end

    task automatic do_req(input int idx, input logic w, input logic r, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_d,
                          input logic exp_e, input bit hold);
        exp_t x;
        bit   seen;
        @(negedge clk);
        we_v[idx]   = w;
        rd_v[idx]   = r;
        addr_v[idx] = a;
        data_v[idx] = d;
        x.cyc  = cyc + lat[idx];
        x.err  = exp_e;
        x.data = exp_d;
        exp_q[idx].push_back(x);
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (get_ack(idx) === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL dut%0d_ack_timeout: no ack within 64 cycles (addr %0d)", idx, a);
        end
        if (hold) @(negedge clk);
        we_v[idx] = 1'b0;
        rd_v[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] wide;
        wide = {32'hDEAD_BEEF, 192'h0, 32'h1234_5678};
        for (int i = 0; i < 3; i++) begin
            addr_v[i] = '0;
            data_v[i] = '0;
            we_v[i]   = 1'b0;
            rd_v[i]   = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("reset_ack", DW'(ack0), DW'(0));
        check("reset_err", DW'(err0), DW'(0));
        check("reset_data", dout0, DW'(0));

        // LATENCY=4 directed vectors
        do_req(0, 1, 0, 3, DW'(32'h5), DW'(0), 0, 0);
        do_req(0, 0, 1, 3, DW'(0), DW'(32'h5), 0, 0);
        do_req(0, 1, 1, 1, DW'(32'hA), DW'(32'h5), 0, 0);
        do_req(0, 0, 1, 1, DW'(0), DW'(32'hA), 0, 0);
        do_req(0, 1, 0, 2, DW'(32'h3), DW'(32'hA), 0, 0);

        // Abort a write to line 2 with reset while BUSY
        @(negedge clk);
        we_v[0] = 1'b1; addr_v[0] = 2; data_v[0] = DW'(32'h7);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ack", DW'(ack0), DW'(0));
        check("abort_data", dout0, DW'(0));
        @(negedge clk);
        we_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        do_req(0, 0, 1, 2, DW'(0), DW'(32'h3), 0, 0);
        do_req(0, 1, 0, 2, DW'(32'h9), DW'(32'h3), 0, 0);
        do_req(0, 0, 1, 2, DW'(0), DW'(32'h9), 0, 0);
        do_req(0, 1, 0, 5, wide, DW'(32'h9), 0, 0);
        do_req(0, 0, 1, 5, DW'(0), wide, 0, 0);

        // Out-of-range line 16: flagged and dropped, or aliased onto line 0
        do_req(0, 1, 0, 0, DW'(32'h11), wide, 0, 0);
        do_req(0, 1, 0, 16, DW'(32'h22), wide, ERR_EN, 0);
        do_req(0, 0, 1, 0, DW'(0), ERR_EN ? DW'(32'h11) : DW'(32'h22), 0, 0);
        do_req(0, 0, 1, 16, DW'(0), ERR_EN ? DW'(0) : DW'(32'h22), ERR_EN, 0);

        // LATENCY=1 and LATENCY=8, request held through the ACK cycle
        do_req(1, 1, 0, 4, DW'(32'h44), DW'(0), 0, 1);
        do_req(1, 0, 1, 4, DW'(0), DW'(32'h44), 0, 1);
        do_req(2, 1, 0, 4, DW'(32'h88), DW'(0), 0, 1);
        do_req(2, 0, 1, 4, DW'(0), DW'(32'h88), 0, 1);

        repeat (12) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d_pending_acks", i), DW'(exp_q[i].size()), DW'(0));
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ddr3_line_resp.md
DDR3_LINE_RESP -- requirements
Module: ddr3_line_resp

Interface
REQ-001 SHALL have parameter DATA_W, default 256, line width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32, request address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, log2 of stored lines.
REQ-004 SHALL have parameter LATENCY, default 4, cycles from request capture to ack (legal range 1..255).
REQ-005 SHALL have ports: clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have ports: rst  input  1  reset, asynchronous and active-low.
REQ-007 SHALL have ports: addr_i  input  ADDR_W  line index of request.
REQ-008 SHALL have ports: data_i  input  DATA_W  write line data.
REQ-009 SHALL have ports: we_i  input  1  write request level.
REQ-010 SHALL have ports: rd_i  input  1  read request level.
REQ-011 SHALL have ports: data_o  output  DATA_W  last read line.
REQ-012 SHALL have ports: ack_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have ports: err_o  output  1  address-range error flag; tied 0 when LINE_RESP_ERR_EN is undefined.

Function
REQ-014 SHALL act as the responder for a level-request/pulse-ack line protocol; the initiator holds we_i/rd_i, addr_i and data_i stable until it sees ack_o.
REQ-015 SHALL use FSM states IDLE, BUSY, ACK.
REQ-016 In IDLE, when we_i or rd_i is high at a rising edge, it SHALL capture addr_i, data_i and the operation, load the latency counter with LATENCY-1, and enter BUSY; if LATENCY==1 it SHALL enter ACK directly.
REQ-017 If we_i and rd_i are both high on capture, the write SHALL win and the read SHALL be dropped.
REQ-018 In BUSY it SHALL decrement the counter each cycle and enter ACK when the counter reaches 0, ignoring all input changes.
REQ-019 On the edge entering ACK, it SHALL commit a write to line addr[DEPTH_LOG2-1:0], or load data_o from that line for a read.
REQ-020 In ACK, ack_o SHALL be high for exactly one cycle, after which the FSM returns to IDLE.
REQ-021 A request still high during the ACK cycle SHALL NOT be re-captured; the first possible capture is the cycle after ACK, so back-to-back requests are served with one IDLE cycle between them.
REQ-022 Total latency SHALL be: request sampled at edge T gives ack_o high during cycle T+LATENCY.
REQ-023 data_o SHALL hold its value across writes and idle periods and change only on a read commit.
REQ-024 When we_i and rd_i drop while BUSY (protocol violation), the captured operation SHALL still complete and ack.

Reset
REQ-025 On rst low, the FSM SHALL enter IDLE asynchronously, with ack_o=0, err_o=0, data_o=0 and the counter at 0.
REQ-026 Stored line contents SHALL NOT be reset, and a read before any write SHALL return undefined data.
REQ-027 Reset asserted mid-transaction SHALL abort it, with no write committed and no ack issued.

Configuration
REQ-028 With LINE_RESP_ERR_EN defined, a captured addr >= 2**DEPTH_LOG2 SHALL still ack after LATENCY cycles, with err_o high in the same cycle as ack_o, the write suppressed and data_o loaded with all-zeros on a read.
REQ-029 Without LINE_RESP_ERR_EN, the upper address bits SHALL be ignored (aliasing), and err_o SHALL be constant 0.

Structure
REQ-030 Package ddr3_line_pkg SHALL hold the FSM state enumeration and the default DATA_W/ADDR_W constants, shared with the DDR3 controller side.
REQ-031 Storage SHALL be the sub-module ddr3_line_ram: single port, synchronous write, registered read, 2**DEPTH_LOG2 x DATA_W.

Verification
REQ-032 Reset, then write addr 3 data 0x...0005 (LATENCY=4) SHALL give ack_o in cycle T+4, one cycle wide, with data_o still 0.
REQ-033 Write addr 3 = 0x5, then rd_i raised in the cycle after ack SHALL give ack in T+1+4 with data_o[31:0]=0x5.
REQ-034 we_i and rd_i both high at addr 1 with data 0xA SHALL write; a later read of addr 1 SHALL return 0xA, and data_o SHALL be unchanged at the first ack.
REQ-035 rst pulsed low during BUSY of a write to addr 2 = 0x7 SHALL give no ack, and a later write/read sequence SHALL then operate normally.
REQ-036 Sweep LATENCY=1 and LATENCY=8 SHALL give ack at T+1 and T+8, with no double ack while the request is held through ACK.
REQ-037 With LINE_RESP_ERR_EN, a write to addr 16 (DEPTH_LOG2=4) SHALL give err_o=ack_o=1 and leave addr 0 unchanged; without the macro, addr 16 SHALL alias to addr 0.
